// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like arbiter: requester owner tags, FSM states and size codes.
// Optional round-robin arbitration is enabled with ARB_ROUND_ROBIN_EN (see sram_like_arbiter.sv).
package sram_like_arbiter_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_INST) ? OWNER_DATA : OWNER_INST;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// Owner FIFO: remembers which requester owns each accepted, unanswered transaction, in order.
module sram_like_arbiter_owner_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  logic   pop_i,
    input  owner_e din_i,
    output logic   full_o,
    output logic   empty_o,
    output owner_e head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_e           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= OWNER_INST;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between the IF and MEM requesters; routes responses via an owner FIFO.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed data-over-inst priority.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              proto_err
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, owner_d;
    owner_e     pick, cur_owner, head;
    logic       fifo_full, fifo_empty;
    logic       push, pop;
    logic       proto_err_q, proto_err_d;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e     rr_q, rr_d;
`endif

    // Requester choice when idle; only matters when both are requesting.
    always_comb begin
        pick = OWNER_INST;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = rr_q;
`else
            pick = OWNER_DATA;
`endif
        end else if (data_req) begin
            pick = OWNER_DATA;
        end
    end

    assign cur_owner = (state_q == ARB_LOCK) ? owner_q : pick;
    assign push      = m_req && m_addr_ok;
    assign pop       = m_data_ok && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_INST;
            proto_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q        <= OWNER_DATA;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            proto_err_q <= proto_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Grant is latched when the bridge does not accept in the pick cycle and held until addr_ok.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q | (m_data_ok & fifo_empty);
`ifdef ARB_ROUND_ROBIN_EN
        rr_d        = push ? other_owner(cur_owner) : rr_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (m_req && !m_addr_ok) begin
                    state_d = ARB_LOCK;
                    owner_d = pick;
                end
            end
            ARB_LOCK: begin
                if (push) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_size       = '0;
        m_addr       = '0;
        m_wdata      = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (!reset && !fifo_full && (state_q == ARB_LOCK || inst_req || data_req)) begin
            m_req = 1'b1;
        end
        if (m_req) begin
            if (cur_owner == OWNER_DATA) begin
                m_wr    = data_wr;
                m_size  = data_size;
                m_addr  = data_addr;
                m_wdata = data_wdata;
            end else begin
                m_wr    = inst_wr;
                m_size  = inst_size;
                m_addr  = inst_addr;
                m_wdata = inst_wdata;
            end
            inst_addr_ok = m_addr_ok && (cur_owner == OWNER_INST);
            data_addr_ok = m_addr_ok && (cur_owner == OWNER_DATA);
        end
    end

    assign inst_data_ok = !reset && pop && (head == OWNER_INST);
    assign data_data_ok = !reset && pop && (head == OWNER_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign proto_err    = proto_err_q;

    sram_like_arbiter_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (m_data_ok),
        .din_i   (cur_owner),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed and randomized bench for sram_like_arbiter against a queue-based transaction model.
module tb_sram_like_arbiter;

    localparam int unsigned OUTSTANDING = 2;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;

    logic clk = 1'b0;
    logic reset;
    logic              inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata, inst_rdata;
    logic              data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic              m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]        m_size;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic              proto_err;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .OUTSTANDING (OUTSTANDING),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata),
        .proto_err    (proto_err)
    );

    int tests = 0;
    int fails = 0;

    // Transaction model: owners (0=inst, 1=data) of accepted, unanswered requests.
    int mq[$];
    int locked;
    int rr;
    bit perr;
    bit acc_i, acc_d;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        locked = -1;
        rr     = 1;
        perr   = 1'b0;
        acc_i  = 1'b0;
        acc_d  = 1'b0;
    endtask

    function automatic int model_pick();
        if (locked >= 0) return locked;
        if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            return rr;
`else
            return 1;
`endif
        end
        if (data_req) return 1;
        if (inst_req) return 0;
        return -1;
    endfunction

    // Check one cycle against the model, then advance the model across the rising edge.
    task automatic tick();
        int  cur;
        bit  mreq;
        #1;
        cur  = model_pick();
        mreq = (cur >= 0) && (mq.size() < OUTSTANDING);
        chk("m_req", m_req, mreq);
        chk("m_addr", m_addr, !mreq ? '0 : (cur == 1 ? data_addr : inst_addr));
        chk("m_wr", m_wr, !mreq ? 1'b0 : (cur == 1 ? data_wr : inst_wr));
        chk("m_size", m_size, !mreq ? 2'b0 : (cur == 1 ? data_size : inst_size));
        chk("m_wdata", m_wdata, !mreq ? '0 : (cur == 1 ? data_wdata : inst_wdata));
        chk("inst_addr_ok", inst_addr_ok, mreq && m_addr_ok && cur == 0);
        chk("data_addr_ok", data_addr_ok, mreq && m_addr_ok && cur == 1);
        chk("inst_data_ok", inst_data_ok, m_data_ok && mq.size() > 0 && mq[0] == 0);
        chk("data_data_ok", data_data_ok, m_data_ok && mq.size() > 0 && mq[0] == 1);
        chk("inst_rdata", inst_rdata, m_rdata);
        chk("data_rdata", data_rdata, m_rdata);
        chk("proto_err", proto_err, perr);
        @(posedge clk);
        acc_i = 1'b0;
        acc_d = 1'b0;
        if (m_data_ok) begin
            if (mq.size() == 0) perr = 1'b1;
            else void'(mq.pop_front());
        end
        if (mreq && m_addr_ok) begin
            mq.push_back(cur);
            locked = -1;
            rr     = 1 - cur;
            if (cur == 1) acc_d = 1'b1;
            else acc_i = 1'b1;
        end else if (mreq) begin
            locked = cur;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        inst_req = 0; data_req = 0; m_addr_ok = 0;
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            m_data_ok = 1; m_rdata = $urandom;
            tick();
        end
        m_data_ok = 0;
    endtask

    task automatic rand_stim();
        if (acc_i || !inst_req) begin
            inst_req  = 1'($urandom_range(0, 1));
            inst_addr = $urandom;
            inst_size = 2'($urandom_range(0, 2));
        end
        if (acc_d || !data_req) begin
            data_req   = 1'($urandom_range(0, 1));
            data_wr    = 1'($urandom_range(0, 1));
            data_addr  = $urandom;
            data_wdata = $urandom;
            data_size  = 2'($urandom_range(0, 2));
        end
        m_addr_ok = 1'($urandom_range(0, 1));
        m_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
        m_rdata   = $urandom;
    endtask

    initial begin
        int g;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: simultaneous requests, data first, responses routed in order
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000;
        tick(); tick();
        m_addr_ok = 1;
        #1;
        chk("t1_data_addr_ok", data_addr_ok, 1);
        chk("t1_inst_addr_ok_blocked", inst_addr_ok, 0);
        tick();
        data_req = 0;
        #1;
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_inst_m_addr", m_addr, 32'h1000);
        tick();
        inst_req = 0; m_addr_ok = 0;
        tick();
        m_data_ok = 1; m_rdata = 32'h1111_2222;
        #1;
        chk("t1_first_data_ok", {inst_data_ok, data_data_ok}, 2'b01);
        tick();
        m_rdata = 32'h3333_4444;
        #1;
        chk("t1_second_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
        tick();
        m_data_ok = 0;
        tick();

        // 2: grant lock while the bridge stalls
        data_req = 1; data_addr = 32'h2000; inst_req = 1; inst_addr = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_m_addr", m_addr, 32'h2000);
            chk("t2_inst_addr_ok", inst_addr_ok, 0);
            tick();
        end
        m_addr_ok = 1;
        tick();
        data_req = 0;
        tick();
        drain();

        // 3: outstanding limit with back-to-back inst reads
        inst_req = 1; inst_addr = 32'h100; m_addr_ok = 1;
        tick();
        inst_addr = 32'h104;
        tick();
        inst_addr = 32'h108;
        #1;
        chk("t3_full_m_req", m_req, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        #1;
        chk("t3_inst_data_ok", inst_data_ok, 1);
        chk("t3_inst_rdata", inst_rdata, 32'hDEADBEEF);
        chk("t3_pop_no_push", inst_addr_ok, 0);
        tick();
        m_data_ok = 0;
        #1;
        chk("t3_third_accept", inst_addr_ok, 1);
        tick();
        drain();

        // 4: push and pop in one cycle, then pointer wrap over many transactions
        data_req = 1; data_addr = 32'h3000; m_addr_ok = 1;
        tick();
        data_addr = 32'h3004; m_data_ok = 1;
        #1;
        chk("t4_push_pop", {data_addr_ok, data_data_ok}, 2'b11);
        tick();
        data_addr = 32'h3008; m_data_ok = 0;
        #1;
        chk("t4_count_kept", m_req, 1);
        tick();
        data_req = 0;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                data_req = 1; inst_req = 0; data_addr = $urandom; data_wr = 1'($urandom_range(0, 1));
            end else begin
                inst_req = 1; data_req = 0; inst_addr = $urandom;
            end
            m_addr_ok = 1;
            m_data_ok = (mq.size() > 0);
            m_rdata   = $urandom;
            tick();
        end
        drain();

        // 5: response with nothing outstanding, then reset while busy
        m_data_ok = 1;
        #1;
        chk("t5_dropped", {inst_data_ok, data_data_ok}, 0);
        tick();
        m_data_ok = 0;
        #1;
        chk("t5_proto_err", proto_err, 1);
        tick(); tick();
        inst_req = 1; inst_addr = 32'h200; m_addr_ok = 1;
        tick();
        inst_addr = 32'h204;
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h4000;
        m_data_ok = 1; m_rdata = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_m_req", m_req, 0);
        chk("t5_rst_m_addr", m_addr, 0);
        chk("t5_rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
        chk("t5_rst_proto_err", proto_err, 0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 6: both requesting continuously
        do_reset();
        inst_req = 1; inst_addr = 32'h500; data_req = 1; data_addr = 32'h600; m_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            m_data_ok = (mq.size() > 0);
            #1;
            g = data_addr_ok ? 1 : (inst_addr_ok ? 0 : -1);
`ifdef ARB_ROUND_ROBIN_EN
            chk("t6_grant", g, (i % 2 == 0) ? 1 : 0);
`else
            chk("t6_grant", g, 1);
`endif
            tick();
            if (acc_d) data_addr = data_addr + 4;
            if (acc_i) inst_addr = inst_addr + 4;
        end
        drain();

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_stim();
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
